// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: debug run/step/halt, end-of-program drain and
// hazard-driven stage enables/flushes. Optional cycle counter under PIPE_CTRL_CYCLE_CNT_EN.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_CNT       = 32
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_halt_req,
    input  logic              i_end_prog,
    input  logic              i_dmem_wait,
    input  logic              i_load_use,
    input  logic              i_branch_taken,
    output logic              o_pc_en,
    output logic              o_if_id_en,
    output logic              o_id_ex_en,
    output logic              o_ex_mem_en,
    output logic              o_mem_wb_en,
    output logic              o_if_id_flush,
    output logic              o_id_ex_flush,
    output logic [1:0]        o_state,
    output logic              o_done,
    output logic [NB_CNT-1:0] o_cycle_cnt
);

    // state    | meaning
    // ST_HALT  | pipeline stopped, waiting for a debug command
    // ST_RUN   | free running until halt request or end of program
    // ST_STEP  | one non-frozen pipeline cycle, then back to halt
    // ST_DRAIN | front end frozen, back end retires the last instructions
    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int NB_DRAIN = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES);

    state_t              state;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                done;
    logic                frozen;
    logic                drain_last;

    assign frozen     = (state != ST_HALT) && i_dmem_wait;
    // Treat a zero load like one so a degenerate DRAIN_CYCLES cannot wrap.
    assign drain_last = (drain_cnt <= NB_DRAIN'(1));

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state     <= ST_HALT;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_HALT: begin
                    if (!done) begin
                        if (i_run) begin
                            state <= ST_RUN;
                        end else if (i_step) begin
                            state <= ST_STEP;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_end_prog && !frozen) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end else if (i_halt_req) begin
                        state <= ST_HALT;
                    end
                end
                ST_STEP: begin
                    if (!frozen) begin
                        if (i_end_prog) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= ST_HALT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!frozen) begin
                        if (drain_last) begin
                            state     <= ST_HALT;
                            drain_cnt <= '0;
                            done      <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - NB_DRAIN'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    // Enables and flushes follow the registered state and the live hazard inputs.
    always_comb begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_en    = 1'b0;
        o_ex_mem_en   = 1'b0;
        o_mem_wb_en   = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        if (i_rst_n && !i_dmem_wait) begin
            case (state)
                ST_RUN, ST_STEP: begin
                    o_pc_en     = 1'b1;
                    o_if_id_en  = 1'b1;
                    o_id_ex_en  = 1'b1;
                    o_ex_mem_en = 1'b1;
                    o_mem_wb_en = 1'b1;
                    if (i_branch_taken) begin
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (i_load_use) begin
                        o_pc_en       = 1'b0;
                        o_if_id_en    = 1'b0;
                        o_id_ex_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    o_id_ex_en    = 1'b1;
                    o_id_ex_flush = 1'b1;
                    o_ex_mem_en   = 1'b1;
                    o_mem_wb_en   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_state = state;
    assign o_done  = done;

`ifdef PIPE_CTRL_CYCLE_CNT_EN
    logic [NB_CNT-1:0] cycle_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            cycle_cnt <= '0;
        end else if (o_ex_mem_en && !(&cycle_cnt)) begin
            cycle_cnt <= cycle_cnt + NB_CNT'(1);
        end
    end

    assign o_cycle_cnt = cycle_cnt;
`else
    assign o_cycle_cnt = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 5-stage CPU pipeline. It owns the enable and flush lines of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It arbitrates between debug-unit commands (run, step, halt), end-of-program drain, and datapath hazards (memory wait, load-use, taken branch). It sits beside the hazard unit and the debug unit, and every pipeline register's `i_en` and flush input is driven from here.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 4: cycles the back end keeps running after end-of-program is detected in ID.
- `NB_CNT`, default 32: width of the cycle counter.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_run` in 1: debug command, continuous run.
- `i_step` in 1: debug command, execute one pipeline cycle.
- `i_halt_req` in 1: debug command, stop.
- `i_end_prog` in 1: end-of-program instruction decoded in ID.
- `i_dmem_wait` in 1: data memory not ready.
- `i_load_use` in 1: load-use hazard from the hazard unit.
- `i_branch_taken` in 1: branch/jump resolved taken in EX.
- `o_pc_en` out 1: PC update enable.
- `o_if_id_en` out 1: IF/ID register enable.
- `o_id_ex_en` out 1: ID/EX register enable.
- `o_ex_mem_en` out 1: EX/MEM register enable.
- `o_mem_wb_en` out 1: MEM/WB register enable.
- `o_if_id_flush` out 1: load zeros (bubble) into IF/ID at the next edge.
- `o_id_ex_flush` out 1: load zeros (bubble) into ID/EX at the next edge.
- `o_state` out 2: current state encoding.
- `o_done` out 1: program finished; sticky.
- `o_cycle_cnt` out `NB_CNT`: count of active pipeline cycles.

## Operation
States:
- HALT (`2'd0`): all enables 0, all flushes 0.
- RUN (`2'd1`): base enable 1 for every stage.
- STEP (`2'd2`): base enable 1 for every stage.
- DRAIN (`2'd3`): `o_pc_en` = 0 and `o_if_id_en` = 0; `o_id_ex_en` = 1 with `o_id_ex_flush` = 1; EX/MEM and MEM/WB enabled.

Transitions:
- HALT → RUN when `i_run` = 1.
- HALT → STEP when `i_step` = 1 and `i_run` = 0.
- HALT ignores `i_run` and `i_step` while `o_done` = 1.
- RUN → HALT when `i_halt_req` = 1.
- RUN → DRAIN when `i_end_prog` = 1 and the cycle is not frozen. This takes priority over `i_halt_req`.
- STEP → HALT after the first non-frozen cycle, or → DRAIN if `i_end_prog` = 1 in that cycle.
- A frozen STEP cycle stays in STEP.
- DRAIN loads a down-counter with `DRAIN_CYCLES`. The counter decrements on each non-frozen cycle.
- DRAIN → HALT on the cycle the counter reaches 1; `o_done` is set at the same edge.
- `i_halt_req` is ignored in STEP and DRAIN.

Hazard overrides, applied only in RUN, STEP and DRAIN, in priority order:
- `i_dmem_wait`: every enable and flush is 0 (full freeze).
- `i_branch_taken`: `o_pc_en` = 1, `o_if_id_flush` = 1, `o_id_ex_flush` = 1. Wins over `i_load_use`, because the dependent instruction is being squashed.
- `i_load_use`: `o_pc_en` = 0, `o_if_id_en` = 0, `o_id_ex_flush` = 1; EX/MEM and MEM/WB stay enabled.
- `i_branch_taken` and `i_load_use` are ignored in DRAIN, where the front end is already frozen.

Flush and enable rules:
- A flush is only asserted together with that register's enable = 1.
- Flush has priority over data inside the register.

Cycle counter:
- Increments once per cycle in which `o_ex_mem_en` = 1.
- Saturates at all-ones.

Reset:
- Every output 0, state HALT, drain counter 0, `o_done` 0.
- A reset in the middle of any state returns to HALT at that edge.

## Timing
- State, drain counter, `o_done` and `o_cycle_cnt` are registered.
- Enables and flushes are combinational from the registered state plus the current hazard inputs.
- Command latency: `i_run` or `i_step` sampled high at edge N puts the state in RUN/STEP after N; enables rise in the cycle following edge N.
- `i_halt_req` sampled at edge N: enables are 0 from edge N onward.
- STEP produces exactly one non-frozen enable cycle per command.
- DRAIN lasts exactly `DRAIN_CYCLES` non-frozen cycles; `o_done` rises at the edge that ends the last one.

## Configuration
- `PIPE_CTRL_CYCLE_CNT_EN` defined: the cycle counter is implemented as described above.
- `PIPE_CTRL_CYCLE_CNT_EN` undefined: no counter logic is built and `o_cycle_cnt` is tied to 0.

## Test plan
- Reset with `i_rst_n` = 0 for 2 cycles, all other inputs 0 → all outputs 0, `o_state` = 0. Then pulse `i_run` for 1 cycle → `o_state` = 1 and all five enables = 1 on the next cycle.
- From HALT, pulse `i_step` 3 times, 5 cycles apart → 3 single enable cycles. With the counter macro defined, `o_cycle_cnt` = 3 and the state returns to 0 after each step.
- In RUN, assert `i_load_use` for 1 cycle → `o_pc_en` = 0, `o_if_id_en` = 0, `o_id_ex_flush` = 1, `o_ex_mem_en` = 1. Assert `i_load_use` and `i_branch_taken` together → `o_pc_en` = 1 and both flushes = 1.
- In RUN, hold `i_dmem_wait` for 3 cycles → all enables 0 for those 3 cycles and `o_cycle_cnt` is unchanged.
- In RUN, pulse `i_end_prog` with `DRAIN_CYCLES` = 4 → `o_state` = 3 for 4 cycles with `o_pc_en` = 0. Then `o_state` = 0 and `o_done` = 1, and a following `i_run` pulse is ignored.
- Assert reset while in DRAIN with 2 drain cycles remaining → next cycle `o_state` = 0, `o_done` = 0, `o_cycle_cnt` = 0.
